// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: shares one FIFO write port between NUM_REQ push producers.
// Each producer holds the grant for one 4-phase word or for a stream burst. Producers
// are served round-robin, and a stream burst gives way after MAX_BURST beats when
// another producer is waiting.
module fifo_push_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 8,
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CW = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] data_in_i,
  input  logic [NUM_REQ-1:0]       stream_mode_i,
  output logic [NUM_REQ-1:0]       ack_o,
  input  logic                     fifo_full_i,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wr_data_o,
  output logic [GW-1:0]            grant_id_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {StIdle, StHsWrite, StHsAck, StStream} state_e;

  state_e           state_q;
  logic [GW-1:0]    grant_q;
  logic [GW-1:0]    last_grant_q;
  logic [CW-1:0]    burst_q;
  // Keeps the write data at zero from reset until the first grant.
  logic             data_live_q;

  logic [WIDTH-1:0]   data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant_onehot;
  logic               req_g;
  logic               others_pending;
  logic               xfer;
  logic [CW-1:0]      burst_inc;
  logic               cap_hit;
  logic [GW-1:0]      pick;
  logic               found;
  logic [GW:0]        cand;

  // Unpack the flat per-producer data bus.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      data_arr[k] = data_in_i[k*WIDTH +: WIDTH];
    end
  end

  assign grant_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
  assign req_g          = req_i[grant_q];
  assign others_pending = |(req_i & ~grant_onehot);
  assign xfer           = (state_q == StStream) & req_g & ~fifo_full_i;
  assign burst_inc      = burst_q + CW'(1);
  assign cap_hit        = (burst_inc == CW'(MAX_BURST));

  // Round-robin pick: first set request after last_grant, wrapping around.
  always_comb begin
    pick  = last_grant_q;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(NUM_REQ)) begin
        cand = cand - (GW+1)'(NUM_REQ);
      end
      if (!found && req_i[cand[GW-1:0]]) begin
        found = 1'b1;
        pick  = cand[GW-1:0];
      end
    end
  end

  // Grant FSM: grant, 4-phase write/ack sequencing, stream burst accounting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      burst_q      <= '0;
      data_live_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            grant_q      <= pick;
            last_grant_q <= pick;
            burst_q      <= '0;
            data_live_q  <= 1'b1;
            // Mode is sampled once here; later changes wait for the next grant.
            state_q      <= stream_mode_i[pick] ? StStream : StHsWrite;
          end
        end
        StHsWrite: begin
          // A dropped request here is a protocol violation: abandon without writing.
          if (!req_g) begin
            state_q <= StIdle;
          end else if (!fifo_full_i) begin
            state_q <= StHsAck;
          end
        end
        StHsAck: begin
          if (!req_g) begin
            state_q <= StIdle;
          end
        end
        StStream: begin
          if (!req_g) begin
            state_q <= StIdle;
          end else if (xfer) begin
            if (cap_hit) begin
              burst_q <= '0;
              // Yield only if someone else is waiting; otherwise keep streaming.
              if (others_pending) begin
                state_q <= StIdle;
              end
            end else begin
              burst_q <= burst_inc;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write strobe and acks decode straight from state so a reset drops them at once.
  always_comb begin
    ack_o        = '0;
    fifo_wr_en_o = 1'b0;
    unique case (state_q)
      StHsWrite: fifo_wr_en_o = req_g & ~fifo_full_i;
      StHsAck:   ack_o        = grant_onehot;
      StStream: begin
        fifo_wr_en_o = xfer;
        ack_o        = xfer ? grant_onehot : '0;
      end
      default: ;
    endcase
  end

  assign fifo_wr_data_o = data_live_q ? data_arr[grant_q] : '0;
  assign grant_id_o     = grant_q;
  assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: a cycle-level reference model checked on every
// cycle, scripted producers, and literal expectations on the write log per scenario.
module tb_fifo_push_arbiter;

  localparam int WIDTH     = 32;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 8;
  localparam int GW        = 2;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] din;
  logic [NUM_REQ-1:0]       mode;
  logic [NUM_REQ-1:0]       ack;
  logic                     full;
  logic                     wr_en;
  logic [WIDTH-1:0]         wr_data;
  logic [GW-1:0]            gid;
  logic                     busy;

  fifo_push_arbiter #(
    .WIDTH    (WIDTH),
    .NUM_REQ  (NUM_REQ),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_i         (req),
    .data_in_i     (din),
    .stream_mode_i (mode),
    .ack_o         (ack),
    .fifo_full_i   (full),
    .fifo_wr_en_o  (wr_en),
    .fifo_wr_data_o(wr_data),
    .grant_id_o    (gid),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state.
  int m_owner;
  int m_ptr;
  int m_beats;
  bit m_stream;
  bit m_written;
  int hs_wr_cnt;

  // Producer scripts: kind 0 = idle, 1 = 4-phase, 2 = stream.
  int          p_kind  [NUM_REQ];
  int          p_left  [NUM_REQ];
  logic [31:0] p_next  [NUM_REQ];
  bit          p_wait  [NUM_REQ];
  int          p_raise [NUM_REQ];
  int          p_ackc  [NUM_REQ];

  logic [31:0] log_d[$];
  int          log_g[$];
  int          log_c[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = NUM_REQ - 1;
    m_beats   = 0;
    m_stream  = 1'b0;
    m_written = 1'b0;
    hs_wr_cnt = 0;
  endtask

  // Compare DUT outputs to the model for this cycle, then advance the model by one edge.
  task automatic model_check();
    logic [NUM_REQ-1:0] e_ack;
    logic [NUM_REQ-1:0] others;
    logic               e_wr;
    int                 o;
    int                 j;
    bit                 f;
    if (!rstn) begin
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(gid), 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      model_reset();
      return;
    end
    o     = m_owner;
    e_ack = '0;
    e_wr  = 1'b0;
    if (o >= 0) begin
      if (!m_stream && !m_written) begin
        e_wr = req[o] & ~full;
      end else if (!m_stream) begin
        e_ack[o] = 1'b1;
      end else begin
        e_wr     = req[o] & ~full;
        e_ack[o] = e_wr;
      end
    end
    chk("ack", 32'(ack), 32'(e_ack));
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    chk("busy", 32'(busy), (o >= 0) ? 32'd1 : 32'd0);
    if (o >= 0) chk("grant_id", 32'(gid), 32'(o));
    if (e_wr) chk("wr_data", wr_data, din[o*WIDTH +: WIDTH]);
    chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
    chk("wr_while_full", 32'(wr_en & full), 32'd0);
    if (wr_en) begin
      log_d.push_back(wr_data);
      log_g.push_back(int'(gid));
      log_c.push_back(cyc);
    end
    // Advance.
    if (o < 0) begin
      f = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
        j = (m_ptr + i) % NUM_REQ;
        if (!f && req[j]) begin
          f       = 1'b1;
          m_owner = j;
        end
      end
      if (f) begin
        m_ptr     = m_owner;
        m_stream  = mode[m_owner];
        m_written = 1'b0;
        m_beats   = 0;
        hs_wr_cnt = 0;
      end
    end else if (!m_stream) begin
      if (wr_en) hs_wr_cnt++;
      if (!req[o]) begin
        chk("hs_one_write", 32'(hs_wr_cnt), 32'd1);
        m_owner = -1;
      end else if (!m_written && !full) begin
        m_written = 1'b1;
      end
    end else begin
      if (!req[o]) begin
        m_owner = -1;
      end else if (!full) begin
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_beats   = 0;
          others    = req;
          others[o] = 1'b0;
          if (others != '0) m_owner = -1;
        end
      end
    end
  endtask

  // One clock: check at negedge, then drive producers just after posedge.
  task automatic tick();
    logic [NUM_REQ-1:0] a;
    @(negedge clk);
    model_check();
    a = ack;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (a[k] && p_ackc[k] < 0) p_ackc[k] = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      case (p_kind[k])
        1: begin
          if (p_wait[k]) begin
            if (!a[k]) begin
              p_wait[k] = 1'b0;
              if (p_left[k] > 0) begin
                req[k]                 = 1'b1;
                din[k*WIDTH +: WIDTH]  = p_next[k];
                p_raise[k]             = cyc;
              end else begin
                p_kind[k] = 0;
              end
            end
          end else if (a[k]) begin
            req[k]    = 1'b0;
            p_left[k] = p_left[k] - 1;
            p_next[k] = p_next[k] + 32'd1;
            p_wait[k] = 1'b1;
          end
        end
        2: begin
          if (a[k]) begin
            p_left[k] = p_left[k] - 1;
            p_next[k] = p_next[k] + 32'd1;
          end
          if (p_left[k] > 0) begin
            req[k]                = 1'b1;
            din[k*WIDTH +: WIDTH] = p_next[k];
          end else begin
            req[k]    = 1'b0;
            p_kind[k] = 0;
          end
        end
        default: req[k] = 1'b0;
      endcase
    end
  endtask

  task automatic start_prod(input int k, input bit strm, input int n, input logic [31:0] base);
    p_kind[k]             = strm ? 2 : 1;
    p_left[k]             = n;
    p_next[k]             = base;
    p_wait[k]             = 1'b0;
    p_raise[k]            = cyc;
    p_ackc[k]             = -1;
    mode[k]               = strm;
    req[k]                = 1'b1;
    din[k*WIDTH +: WIDTH] = base;
  endtask

  task automatic clear_prods();
    for (int k = 0; k < NUM_REQ; k++) begin
      p_kind[k] = 0;
      p_ackc[k] = -1;
    end
    req  = '0;
    mode = '0;
    full = 1'b0;
  endtask

  function automatic bit all_done();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (p_kind[k] != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic run(input int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      tick();
      n++;
    end
    n_vec++;
    if (!all_done()) begin
      n_err++;
      $display("FAIL timeout: producers active after %0d cycles, expected done", budget);
    end
    tick();
    tick();
  endtask

  task automatic wait_log(input int sz, input int budget);
    int n;
    n = 0;
    while (log_d.size() < sz && n < budget) begin
      tick();
      n++;
    end
    chk("wait_log_size", 32'(log_d.size()), 32'(sz));
  endtask

  task automatic do_reset();
    clear_prods();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    log_d.delete();
    log_g.delete();
    log_c.delete();
  endtask

  initial begin
    rstn = 1'b0;
    din  = '0;
    clear_prods();
    model_reset();

    // Reset with every producer requesting; producer 0 must win first after release.
    for (int k = 0; k < NUM_REQ; k++) start_prod(k, 1'b0, 1, 32'h100 + 32'(k));
    tick();
    tick();
    tick();
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    run(200);
    chk("reset_first_grant", 32'(log_g[0]), 32'd0);
    chk("reset_nwrites", 32'(log_d.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("reset_order", 32'(log_g[i]), 32'(i));

    // Single 4-phase push from producer 1.
    do_reset();
    start_prod(1, 1'b0, 1, 32'hA5A5_0001);
    run(100);
    chk("hs_nwrites", 32'(log_d.size()), 32'd1);
    chk("hs_data", log_d[0], 32'hA5A5_0001);
    chk("hs_grant", 32'(log_g[0]), 32'd1);
    chk("hs_write_latency", 32'(log_c[0] - p_raise[1]), 32'd1);
    chk("hs_ack_latency", 32'(p_ackc[1] - p_raise[1]), 32'd2);

    // Round robin among four continuous 4-phase producers.
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) start_prod(k, 1'b0, 2, 32'h1000 * 32'(k + 1));
    run(400);
    chk("rr_nwrites", 32'(log_d.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_order", 32'(log_g[i]), 32'(i % 4));
      chk("rr_data", log_d[i], 32'h1000 * 32'((i % 4) + 1) + 32'(i / 4));
    end

    // Stream of five words from producer 2 with a three-cycle full stall after word two.
    do_reset();
    start_prod(2, 1'b1, 5, 32'h10);
    wait_log(2, 50);
    full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_no_ack", 32'(ack), 32'd0);
      chk("stall_no_wr", 32'(wr_en), 32'd0);
    end
    full = 1'b0;
    run(100);
    chk("stream_nwrites", 32'(log_d.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("stream_data", log_d[i], 32'h10 + 32'(i));
      chk("stream_grant", 32'(log_g[i]), 32'd2);
    end

    // Burst cap: producer 0 streams 20 words while producer 3 waits with one 4-phase word.
    do_reset();
    start_prod(0, 1'b1, 20, 32'h200);
    start_prod(3, 1'b0, 1, 32'h300);
    run(400);
    chk("cap_nwrites", 32'(log_d.size()), 32'd21);
    chk("cap_p3_slot", 32'(log_g[8]), 32'd3);
    chk("cap_p3_data", log_d[8], 32'h300);
    for (int i = 0; i < 21; i++) begin
      if (i != 8) begin
        chk("cap_p0_grant", 32'(log_g[i]), 32'd0);
        chk("cap_p0_data", log_d[i], 32'h200 + 32'((i < 8) ? i : i - 1));
      end
    end

    // Reset in the middle of a six-beat stream; arbitration must restart at producer 0.
    do_reset();
    start_prod(1, 1'b1, 6, 32'h40);
    wait_log(3, 50);
    #1;
    chk("pre_reset_ack", 32'(ack[1]), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) chk("midrst_data", log_d[i], 32'h40 + 32'(i));
    clear_prods();
    tick();
    tick();
    rstn = 1'b1;
    log_d.delete();
    log_g.delete();
    log_c.delete();
    start_prod(1, 1'b0, 1, 32'h51);
    start_prod(0, 1'b0, 1, 32'h50);
    run(100);
    chk("midrst_first_grant", 32'(log_g[0]), 32'd0);
    chk("midrst_second_grant", 32'(log_g[1]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Shares one FIFO write port between NUM_REQ producers.
- Each producer uses the team's push req/ack protocol: 4-phase handshake, or streaming when stream_mode is set.
- Round-robin arbitration. Stream bursts are capped at MAX_BURST beats whenever another producer is waiting.
- Sits between the per-producer push interfaces and the FIFO write side (wr_en/wr_data/full).

Parameters:
- WIDTH, 32, data width per entry.
- NUM_REQ, 4, number of producers (2..16).
- MAX_BURST, 8, stream beats before forced re-arbitration when others are pending (>=1).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  per-producer push request.
- data_in_i  in  NUM_REQ*WIDTH  per-producer data; slice k = [k*WIDTH +: WIDTH].
- stream_mode_i  in  NUM_REQ  per-producer mode: 0 = 4-phase, 1 = stream.
- ack_o  out  NUM_REQ  per-producer acknowledge.
- fifo_full_i  in  1  FIFO full flag.
- fifo_wr_en_o  out  1  FIFO write strobe.
- fifo_wr_data_o  out  WIDTH  FIFO write data.
- grant_id_o  out  max(1,$clog2(NUM_REQ))  currently granted producer, valid when busy_o=1.
- busy_o  out  1  a producer holds the grant.

Behaviour:
- Reset (async assert, deasserted synchronously by the environment):
  - State IDLE; ack_o=0, fifo_wr_en_o=0, fifo_wr_data_o=0, grant_id_o=0, busy_o=0.
  - Burst count 0; round-robin pointer last_grant=NUM_REQ-1, so producer 0 has first priority.
  - Reset mid-transfer aborts immediately. No partial write: wr_en is combinational from state, so it drops with the state.
- States: IDLE, HS_WRITE, HS_ACK, STREAM.
- IDLE:
  - If any req_i is set, pick the first set bit searching from last_grant+1 with wrap-around.
  - At the clock edge: register grant_id and last_grant, and sample stream_mode_i[g].
  - Next state is STREAM if the sampled mode is 1, else HS_WRITE.
  - busy_o is 1 in every state except IDLE.
- HS_WRITE:
  - If req_i[g]=0 (protocol violation): go to IDLE, no write.
  - Else if fifo_full_i=1: stay, no write.
  - Else: fifo_wr_en_o=1 and fifo_wr_data_o=data_in_i[g] combinationally this cycle; next state HS_ACK.
- HS_ACK:
  - ack_o[g] is held at 1 while req_i[g]=1.
  - When req_i[g]=0: next state IDLE; ack_o falls the following cycle, which satisfies the producer's wait for ~ack.
  - No second write occurs, whatever fifo_full_i does.
- 4-phase latency: req seen in IDLE in cycle N → write in N+1 (if not full) → ack high from N+2.
- STREAM:
  - ack_o[g] = fifo_wr_en_o = req_i[g] & ~fifo_full_i; fifo_wr_data_o = data_in_i[g]. Combinational; a transfer occurs at each edge where ack is 1.
  - Burst count increments per transfer, not on full stalls.
  - Exit to IDLE when req_i[g]=0.
  - Also exit to IDLE at the edge where the count reaches MAX_BURST and any other req_i is set. The pointer then advances past g.
  - If the count reaches MAX_BURST and no other producer is pending: the count clears and the grant continues.
  - The count clears on every grant.
- Mode and grant stability:
  - stream_mode_i changes while granted are ignored until the next grant.
  - Non-granted producers always see ack_o=0.
- fifo_wr_data_o outside write cycles: holds data_in_i[grant_id]; only fifo_wr_en_o qualifies it.
- At most one ack_o bit is set at any time, and one write per cycle.
- Requests arriving while busy wait. A producer that drops req before being granted is simply skipped.
- Bench assertions:
  - ack_o is one-hot-or-zero.
  - fifo_wr_en_o never asserts with fifo_full_i=1.
  - Every 4-phase grant produces exactly one write.

Test Plan:
- Reset check: rstn=0 with all req_i=1 → ack_o=0, fifo_wr_en_o=0, busy_o=0. After release, first grant_id_o=0.
- 4-phase push: producer 1 pushes 0xA5A50001, FIFO not full → one write of 0xA5A50001 one cycle after grant. ack_o[1] rises the next cycle and falls one cycle after req drops. Exactly one write total.
- Round robin: producers 0-3 all request 4-phase continuously → write order 0,1,2,3,0,1; no producer granted twice in a row.
- Stream with full: producer 2 streams 5 words (0x10..0x14); fifo_full_i=1 for 3 cycles after the 2nd word → no ack/write during the stall. FIFO receives 0x10..0x14 in order, no duplicates or drops.
- Burst cap: MAX_BURST=8, producer 0 streams 20 words while producer 3 has a 4-phase req pending → producer 3 is granted after exactly 8 beats. Producer 0 resumes and completes all 20 words in order.
- Reset mid-stream: rstn asserted after 3 of 6 beats → wr_en and ack drop in the same cycle, state IDLE. After release, arbitration restarts at producer 0.
